// File: rtl/serializer_frame_unit.sv
// Frame serializer: captures NUM_WORDS x WORD_W words on LOAD/READY and shifts one bit per BIT_EN, word 0 first.
// Optional per-word even parity bit when SERIALIZER_PARITY_EN is defined; BIT_EN=0 stalls with outputs held.
module serializer_frame_unit #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                                                  CLK,
  input  logic                                                  RESET,
  input  logic [NUM_WORDS*WORD_W-1:0]                           PAR_IN,
  input  logic                                                  LOAD,
  output logic                                                  READY,
  input  logic                                                  BIT_EN,
  output logic                                                  SERIAL_OUT,
  output logic                                                  SERIAL_VALID,
  output logic                                                  FRAME_START,
  output logic                                                  WORD_DONE,
  output logic                                                  FRAME_DONE,
  output logic [((NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1)-1:0]  WORD_IDX
);

  localparam int BCW = $clog2(WORD_W + 1);
  localparam int WIW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [BCW-1:0]    BIT_LAST  = BCW'(WORD_W - 1);
  localparam logic [WIW-1:0]    WORD_LAST = WIW'(NUM_WORDS - 1);
  localparam logic [WORD_W-1:0] ONE_LSB   = {{(WORD_W-1){1'b0}}, 1'b1};
  localparam logic [WORD_W-1:0] ONE_MSB   = {1'b1, {(WORD_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
`ifdef SERIALIZER_PARITY_EN
    PAR,
`endif
    SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIW-1:0]    word_cnt_q, word_cnt_d;
  logic              out_q, out_d;
  logic              vld_q, vld_d;
  logic              fs_q, fs_d;
  logic              wd_q, wd_d;
  logic              fd_q, fd_d;
  logic [WIW-1:0]    idx_q, idx_d;
  logic              load_en;
  logic              word_end;
  logic [WORD_W-1:0] shadow [NUM_WORDS];
  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] bit_mask;
  logic              data_bit;

  assign cur_word = shadow[word_cnt_q];
  // Mask-based bit pick avoids a variable index wider than the word
  assign bit_mask = LSB_FIRST ? (ONE_LSB << bit_cnt_q) : (ONE_MSB >> bit_cnt_q);
  assign data_bit = |(cur_word & bit_mask);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    out_d      = out_q;
    vld_d      = 1'b0;
    fs_d       = 1'b0;
    wd_d       = 1'b0;
    fd_d       = 1'b0;
    idx_d      = idx_q;
    load_en    = 1'b0;
    word_end   = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 1'b0;
        if (LOAD) begin
          load_en    = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (BIT_EN) begin
          out_d = data_bit;
          vld_d = 1'b1;
          fs_d  = (word_cnt_q == '0) && (bit_cnt_q == '0);
          idx_d = word_cnt_q;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
            state_d   = PAR;
`else
            word_end  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PAR: begin
        if (BIT_EN) begin
          out_d    = ^cur_word;
          vld_d    = 1'b1;
          idx_d    = word_cnt_q;
          word_end = 1'b1;
          state_d  = SHIFT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // The last emitted bit of a word carries WORD_DONE and decides frame end
    if (word_end) begin
      wd_d = 1'b1;
      if (word_cnt_q == WORD_LAST) begin
        fd_d       = 1'b1;
        word_cnt_d = '0;
        state_d    = IDLE;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      out_q      <= 1'b0;
      vld_q      <= 1'b0;
      fs_q       <= 1'b0;
      wd_q       <= 1'b0;
      fd_q       <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      out_q      <= out_d;
      vld_q      <= vld_d;
      fs_q       <= fs_d;
      wd_q       <= wd_d;
      fd_q       <= fd_d;
      idx_q      <= idx_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < NUM_WORDS; k++) shadow[k] <= PAR_IN[k*WORD_W +: WORD_W];
    end
  end

  assign READY        = (state_q == IDLE);
  assign SERIAL_OUT   = out_q;
  assign SERIAL_VALID = vld_q;
  assign FRAME_START  = fs_q;
  assign WORD_DONE    = wd_q;
  assign FRAME_DONE   = fd_q;
  assign WORD_IDX     = idx_q;

endmodule
